// File: rtl/muldiv_if.sv
// Handshake and result bus between the control path and the multiply/divide unit.
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Control path side: issues requests, observes status and HI/LO.
  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo
  );

  // Unit side: owns HI/LO and the status flags.
  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO pair.
// Works on magnitudes one bit per cycle and applies sign correction in a final FIX cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input logic    clk,
  input logic    reset,
  muldiv_if.slave bus
);

  localparam logic [2:0] OpMultu = 3'b000;
  localparam logic [2:0] OpMult  = 3'b001;
  localparam logic [2:0] OpDivu  = 3'b010;
  localparam logic [2:0] OpDiv   = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;    // high partial product / running remainder
  logic [WIDTH-1:0] r_mq;     // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] r_md;     // multiplicand / divisor magnitude
  logic             r_is_div;
  logic             r_neg_q;  // negate product or quotient
  logic             r_neg_r;  // negate remainder (dividend sign)
  logic             r_div0;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Operand magnitudes for signed ops (op[0] set); unsigned ops pass through.
  logic             w_signed;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  assign w_signed = bus.op[0];
  assign w_mag_a  = (w_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_mag_b  = (w_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Shift-add multiply step: {acc,mq} shifts right, adding md when the LSB is set.
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH-1:0] w_mul_mq;
  assign w_mul_sum = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_md} : '0);
  assign w_mul_acc = w_mul_sum[WIDTH:1];
  assign w_mul_mq  = {w_mul_sum[0], r_mq[WIDTH-1:1]};

  // Restoring divide step: shift the next dividend bit in, keep the difference if no borrow.
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH+1:0] w_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_div_acc;
  logic [WIDTH-1:0] w_div_mq;
  assign w_rem_sh  = {r_acc, r_mq[WIDTH-1]};
  assign w_diff    = {1'b0, w_rem_sh} - {2'b00, r_md};
  assign w_borrow  = w_diff[WIDTH+1];
  assign w_div_acc = w_borrow ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_div_mq  = {r_mq[WIDTH-2:0], ~w_borrow};

  // Final sign correction. With a zero divisor the remainder register ends up holding |a|,
  // so re-applying the dividend sign returns the original operand.
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  assign w_prod     = {r_acc, r_mq};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quo_fix  = r_div0 ? '1 : (r_neg_q ? -r_mq : r_mq);
  assign w_rem_fix  = r_neg_r ? -r_acc : r_acc;

  // Control FSM, datapath iteration and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mq     <= '0;
      r_md     <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            case (bus.op)
              OpMultu, OpMult, OpDivu, OpDiv: begin
                r_is_div <= bus.op[1];
                r_acc    <= '0;
                r_mq     <= w_mag_a;
                r_md     <= w_mag_b;
                r_neg_q  <= w_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                r_neg_r  <= w_signed & bus.a[WIDTH-1];
                r_div0   <= (bus.b == '0);
                r_cnt    <= CW'(WIDTH - 1);
                r_busy   <= 1'b1;
                r_state  <= StCalc;
              end
              OpMthi: begin
                r_hi   <= bus.a;
                r_done <= 1'b1;
              end
              OpMtlo: begin
                r_lo   <= bus.a;
                r_done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        StCalc: begin
          if (bus.flush) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else begin
            if (r_is_div) begin
              r_acc <= w_div_acc;
              r_mq  <= w_div_mq;
            end else begin
              r_acc <= w_mul_acc;
              r_mq  <= w_mul_mq;
            end
            if (r_cnt == '0) begin
              r_state <= StFix;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
        end
        StFix: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          if (!bus.flush) begin
            if (r_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end
            r_done <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed checks of muldiv_unit against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;
  localparam int unsigned W = 32;

  logic clk;
  logic reset;
  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural effect of one op on {hi,lo}.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'b000: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'b001: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'b010: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      3'b011: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else begin
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
      3'b100: m_hi = a;
      3'b101: m_lo = a;
      default: ;
    endcase
  endfunction

  // Called at a sample point (#1 after an edge); returns at the sample where done was seen,
  // so the next call drives start in the done cycle.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit use_exp, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input bit flush_at_start);
    logic [63:0] old;
    int k, nbusy, lat;
    old = {m_hi, m_lo};
    model(op, a, b);
    lat = op[2] ? 0 : W + 1;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.flush = flush_at_start;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    bus.a = $urandom; bus.b = $urandom;
    k = 0; nbusy = 0;
    while (!bus.done && k < W + 10) begin
      chk("excl", {63'b0, bus.done & bus.busy}, 64'd0);
      chk("hold", {bus.hi, bus.lo}, old);
      if (bus.busy) nbusy++;
      @(posedge clk); #1;
      k++;
    end
    chk("excl", {63'b0, bus.done & bus.busy}, 64'd0);
    chk("done", {63'b0, bus.done}, 64'd1);
    chk("latency", 64'(k), 64'(lat));
    chk("busy_cycles", 64'(nbusy), op[2] ? 64'd0 : 64'(W + 1));
    chk("result", {bus.hi, bus.lo}, {m_hi, m_lo});
    if (use_exp) chk("spec_result", {bus.hi, bus.lo}, {exp_hi, exp_lo});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
  endtask

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic [63:0]  old;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    do_reset();
    chk("rst_state", {60'b0, bus.busy, bus.done, 2'b0}, 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);

    // Directed cases with hand-computed expectations.
    run_op(3'b001, 32'hFFFFFFFD, 32'd5, 1, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    run_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 0);
    run_op(3'b011, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op(3'b011, 32'd7, 32'hFFFFFFFE, 1, 32'h00000001, 32'hFFFFFFFD, 0);
    run_op(3'b010, 32'h1234, 32'd0, 1, 32'h00001234, 32'hFFFFFFFF, 0);
    run_op(3'b011, 32'hFFFFFFF9, 32'd0, 1, 32'hFFFFFFF9, 32'hFFFFFFFF, 0);
    run_op(3'b011, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000, 0);
    run_op(3'b100, 32'hCAFEF00D, 32'd0, 1, 32'hCAFEF00D, 32'h80000000, 0);
    run_op(3'b101, 32'h0BADBEEF, 32'd0, 1, 32'hCAFEF00D, 32'h0BADBEEF, 0);
    // Flush together with start in IDLE: start wins.
    run_op(3'b000, 32'd6, 32'd7, 1, 32'd0, 32'd42, 1);

    // Undefined op is ignored.
    old = {m_hi, m_lo};
    bus.start = 1'b1; bus.op = 3'b110; bus.a = 32'h55; bus.b = 32'h3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("nop_flags", {62'b0, bus.busy, bus.done}, 64'd0);
      @(posedge clk); #1;
    end
    chk("nop_hilo", {bus.hi, bus.lo}, old);

    // DIVU, ignored MULT start at cycle 10, then flush in CALC.
    old = {m_hi, m_lo};
    bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'd1000; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    bus.start = 1'b1; bus.op = 3'b001; bus.a = 32'd3; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_ignored", {63'b0, bus.busy}, 64'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_busy", {62'b0, bus.busy, bus.done}, 64'd0);
    for (int i = 0; i < W + 5; i++) begin
      if (bus.done || bus.busy) chk("flush_quiet", {62'b0, bus.busy, bus.done}, 64'd0);
      @(posedge clk); #1;
    end
    chk("flush_hilo", {bus.hi, bus.lo}, old);

    // Flush in FIX cycle.
    bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd9; bus.b = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (W) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("fix_flush_flags", {62'b0, bus.busy, bus.done}, 64'd0);
    chk("fix_flush_hilo", {bus.hi, bus.lo}, old);
    @(posedge clk); #1;
    chk("fix_flush_nodone", {63'b0, bus.done}, 64'd0);

    // Reset in the middle of a MULT.
    bus.start = 1'b1; bus.op = 3'b001; bus.a = 32'hFFFF0001; bus.b = 32'h1234;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("midrst_flags", {62'b0, bus.busy, bus.done}, 64'd0);
    chk("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    run_op(3'b001, 32'hFFFFFFFD, 32'd5, 1, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);

    // Random back-to-back traffic.
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 5));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h80000000; b = '1; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      run_op(op, a, b, 0, '0, '0, 0);
    end

    @(posedge clk); #1;
    chk("final_done_low", {63'b0, bus.done}, 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
